// File: rtl/wb_backdoor_bridge.sv
// Registered Wishbone bridge from the host bus to the ROM/RAM backdoor ports,
// with a per-access timeout, error responses and a small CPU control CSR bank.
module wb_backdoor_bridge #(
  parameter int NUM_ROMS = 1,
  parameter int NUM_RAMS = 2,
  parameter int TIMEOUT  = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           wb_data_i,
  input  logic [31:0]           wb_addr_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_strobe_i,
  input  logic                  wb_we_i,
  output logic [31:0]           wb_data_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic [31:0]           slv_data_o,
  output logic [31:0]           slv_addr_o,
  output logic                  slv_we_o,
  output logic                  slv_cyc_o,
  output logic [NUM_ROMS-1:0]   rom_strobe_o,
  input  logic [32*NUM_ROMS-1:0] rom_data_i,
  input  logic [NUM_ROMS-1:0]   rom_ack_i,
  output logic [NUM_RAMS-1:0]   ram_strobe_o,
  input  logic [32*NUM_RAMS-1:0] ram_data_i,
  input  logic [NUM_RAMS-1:0]   ram_ack_i,
  input  logic [4*NUM_RAMS-1:0] ram_out_i,
  output logic [4*NUM_ROMS-1:0] rom_in_o,
  output logic                  cpu_halt_o,
  output logic                  cpu_reset_o
);

  typedef enum logic [2:0] {S_IDLE, S_FWD, S_CSR, S_ERR, S_RESP} state_t;

  state_t state_reg, state_next;

  logic [31:0]           slv_data_reg, slv_addr_reg, wb_data_reg;
  logic                  slv_we_reg, sel_ram_reg;
  logic [2:0]            sel_idx_reg;
  logic [7:0]            wait_cnt_reg, timeout_cnt_reg, err_cnt_reg;
  logic                  halt_reg, cpu_reset_reg;
  logic [4*NUM_ROMS-1:0] rom_in_reg;

  logic        req, dec_fwd, dec_csr, dec_rom_ok, dec_ram_ok;
  logic [1:0]  region;
  logic [2:0]  dec_idx;
  logic [31:0] csr_rdata, sel_data;
  logic        sel_ack, timeout_hit, fwd_active;

  // Address decode of the incoming host request
  assign req        = wb_cyc_i & wb_strobe_i;
  assign region     = wb_addr_i[17:16];
  assign dec_rom_ok = (region == 2'd0) && ({28'd0, wb_addr_i[13:10]} < 32'(NUM_ROMS));
  assign dec_ram_ok = (region == 2'd1) && ({28'd0, wb_addr_i[12:9]} < 32'(NUM_RAMS));
  assign dec_fwd    = dec_rom_ok | dec_ram_ok;
  assign dec_csr    = (region == 2'd2);
  assign dec_idx    = (region == 2'd0) ? wb_addr_i[12:10] : wb_addr_i[11:9];

  always_comb begin
    csr_rdata = 32'd0;
    case (wb_addr_i[3:2])
      2'd0:    csr_rdata = {30'd0, cpu_reset_reg, halt_reg};
      2'd1:    csr_rdata = 32'(rom_in_reg);
      2'd2:    csr_rdata = 32'(ram_out_i);
      default: csr_rdata = {16'd0, err_cnt_reg, timeout_cnt_reg};
    endcase
  end

  // Per-slave strobes; acks and data from unselected slaves are masked out
  generate
    for (genvar gi = 0; gi < NUM_ROMS; gi++) begin : g_rom
      assign rom_strobe_o[gi] = fwd_active && !sel_ram_reg && (sel_idx_reg == 3'(gi));
    end
    for (genvar gi = 0; gi < NUM_RAMS; gi++) begin : g_ram
      assign ram_strobe_o[gi] = fwd_active && sel_ram_reg && (sel_idx_reg == 3'(gi));
    end
  endgenerate

  assign sel_ack     = (|(rom_strobe_o & rom_ack_i)) | (|(ram_strobe_o & ram_ack_i));
  assign timeout_hit = (wait_cnt_reg == 8'(TIMEOUT - 1));

  always_comb begin
    sel_data = 32'd0;
    for (int k = 0; k < NUM_ROMS; k++)
      if (rom_strobe_o[k]) sel_data = sel_data | rom_data_i[32*k +: 32];
    for (int k = 0; k < NUM_RAMS; k++)
      if (ram_strobe_o[k]) sel_data = sel_data | ram_data_i[32*k +: 32];
  end

  always_ff @(posedge clock) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (req) begin
          if (dec_fwd)      state_next = S_FWD;
          else if (dec_csr) state_next = S_CSR;
          else              state_next = S_ERR;
        end
      end
      S_FWD: begin
        if (!wb_cyc_i)        state_next = S_IDLE;
        else if (sel_ack)     state_next = S_RESP;
        else if (timeout_hit) state_next = S_ERR;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    fwd_active = (state_reg == S_FWD);
    slv_cyc_o  = (state_reg == S_FWD);
    wb_ack_o   = (state_reg == S_RESP) || (state_reg == S_CSR);
    wb_err_o   = (state_reg == S_ERR);
  end

  // CSR accesses complete at the accept edge so the ack can follow one cycle later
  always_ff @(posedge clock) begin
    if (reset) begin
      slv_data_reg    <= 32'd0;
      slv_addr_reg    <= 32'd0;
      slv_we_reg      <= 1'b0;
      sel_ram_reg     <= 1'b0;
      sel_idx_reg     <= 3'd0;
      wait_cnt_reg    <= 8'd0;
      timeout_cnt_reg <= 8'd0;
      err_cnt_reg     <= 8'd0;
      wb_data_reg     <= 32'd0;
      halt_reg        <= 1'b0;
      cpu_reset_reg   <= 1'b1;
      rom_in_reg      <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (req) begin
            slv_data_reg <= wb_data_i;
            slv_addr_reg <= wb_addr_i;
            slv_we_reg   <= wb_we_i;
            sel_ram_reg  <= (region == 2'd1);
            sel_idx_reg  <= dec_idx;
            wait_cnt_reg <= 8'd0;
            if (dec_csr) begin
              wb_data_reg <= csr_rdata;
              if (wb_we_i) begin
                case (wb_addr_i[3:2])
                  2'd0: begin
                    halt_reg      <= wb_data_i[0];
                    cpu_reset_reg <= wb_data_i[1];
                  end
                  2'd1: rom_in_reg <= wb_data_i[4*NUM_ROMS-1:0];
                  2'd3: begin
                    timeout_cnt_reg <= 8'd0;
                    err_cnt_reg     <= 8'd0;
                  end
                  default: ;
                endcase
              end
            end else if (!dec_fwd) begin
              wb_data_reg <= 32'd0;
            end
          end
        end
        S_FWD: begin
          if (wb_cyc_i) begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
            if (sel_ack) begin
              wb_data_reg <= sel_data;
            end else if (timeout_hit) begin
              wb_data_reg <= 32'd0;
              if (timeout_cnt_reg != 8'hFF) timeout_cnt_reg <= timeout_cnt_reg + 8'd1;
            end
          end
        end
        S_ERR: begin
          if (err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign wb_data_o   = wb_data_reg;
  assign slv_data_o  = slv_data_reg;
  assign slv_addr_o  = slv_addr_reg;
  assign slv_we_o    = slv_we_reg;
  assign rom_in_o    = rom_in_reg;
  assign cpu_halt_o  = halt_reg;
  assign cpu_reset_o = cpu_reset_reg;

endmodule

// File: doc/wb_backdoor_bridge.md
Name: wb_backdoor_bridge

Overview:
Registered Wishbone backdoor bridge between the host bus and the ROM/RAM backdoor ports of the 4-bit CPU system. It replaces the combinational address mux used so far. Added over that mux:
- parametrised ROM/RAM counts
- one outstanding transfer with a per-access timeout
- error responses for unmapped addresses
- a small CSR bank for CPU halt/reset control, ROM input-port drive and RAM output-port observation

Parameters:
NUM_ROMS, 1, number of ROM chips behind the bridge (1..8)
NUM_RAMS, 2, number of RAM chips behind the bridge (1..8)
TIMEOUT, 15, slave cycles waited for ack before error (1..255)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
wb_data_i  in  32  host write data
wb_addr_i  in  32  host byte address
wb_cyc_i  in  1  host cycle
wb_strobe_i  in  1  host strobe
wb_we_i  in  1  host write enable
wb_data_o  out  32  read data, registered
wb_ack_o  out  1  one-cycle ack pulse
wb_err_o  out  1  one-cycle error pulse
slv_data_o  out  32  latched write data to all slaves
slv_addr_o  out  32  latched address to all slaves
slv_we_o  out  1  latched write enable
slv_cyc_o  out  1  high while a slave access is active
rom_strobe_o  out  NUM_ROMS  per-ROM strobe
rom_data_i  in  32*NUM_ROMS  ROM read data, chip k at [32k+31:32k]
rom_ack_i  in  NUM_ROMS  ROM acks
ram_strobe_o  out  NUM_RAMS  per-RAM strobe
ram_data_i  in  32*NUM_RAMS  RAM read data
ram_ack_i  in  NUM_RAMS  RAM acks
ram_out_i  in  4*NUM_RAMS  RAM output ports (observed)
rom_in_o  out  4*NUM_ROMS  drive for ROM input ports
cpu_halt_o  out  1  CPU halt
cpu_reset_o  out  1  CPU reset request

Behaviour:
Reset:
- Outputs: wb_ack_o, wb_err_o, strobes, slv_cyc_o = 0; wb_data_o = 0; rom_in_o = 0; cpu_halt_o = 0; cpu_reset_o = 1 (CPU held in reset until the host loads ROM).
- Counters = 0; FSM = IDLE.
- Reset asserted mid-access: all strobes drop at that edge, no ack or err is issued.

Address decode on wb_addr_i[17:16]:
- 0 = ROM, index wb_addr_i[13:10].
- 1 = RAM, index wb_addr_i[12:9].
- 2 = CSR, register wb_addr_i[3:2].
- 3 = unmapped.
- A ROM/RAM index >= NUM_ROMS/NUM_RAMS is unmapped.

FSM states: IDLE, FWD, CSR, ERR, RESP.
- IDLE: when cyc&strobe are high, latch addr, data and we into slv_* and go to FWD, CSR or ERR. Acceptance is the cycle-0 edge.
- FWD:
  - Selected strobe and slv_cyc_o are high from cycle 1. The wait counter starts at 0 and increments each FWD cycle.
  - Selected ack high in cycle N: register its data into wb_data_o and go to RESP. wb_ack_o is high in cycle N+1, so minimum host latency is 2 cycles.
  - Counter reaches TIMEOUT with no ack: drop strobe, go to ERR, increment timeout_cnt.
  - Ack and timeout in the same cycle: ack wins.
  - Acks from unselected slaves are ignored.
- CSR: perform the register access; wb_ack_o is high in the next cycle (latency 1), then IDLE.
- ERR: wb_err_o is high for one cycle with wb_data_o = 0, err_cnt increments, then IDLE.
- RESP: wb_ack_o is high for one cycle, strobe is low, then IDLE.
- A held host strobe starts a new transfer from IDLE on the following cycle.
- Host drops wb_cyc_i in FWD: abort. Strobe drops next edge, return to IDLE, no ack/err, no counter change.

CSR map (word offsets):
- 0 CTRL: bit0 = halt, bit1 = cpu_reset. Read/write; other bits read 0.
- 1 ROM_IN: bits [4*NUM_ROMS-1:0] drive rom_in_o. Read/write.
- 2 RAM_OUT: ram_out_i sampled at the CSR cycle, zero-extended. Read-only; writes are acked and ignored.
- 3 STATUS: [7:0] timeout_cnt and [15:8] err_cnt, both saturating at 255. Any write clears both.
- err_cnt counts every error, including timeouts.

Test Plan:
1. CSR: reset, read CTRL -> 0x2 with ack 1 cycle after accept. Write CTRL=0x1 -> cpu_halt_o=1, cpu_reset_o=0.
2. ROM write: addr 0x0000_0004, data 0xA, ROM0 acks after 3 cycles -> rom_strobe_o[0] high exactly 3 cycles, then wb_ack_o one cycle later. Read back -> wb_data_o=0xA.
3. RAM select: addr 0x0001_0200 -> only ram_strobe_o[1] asserted. Addr 0x0001_0400 with NUM_RAMS=2 -> wb_err_o pulse, no strobe, STATUS=0x0100.
4. Timeout: RAM0 never acks -> strobe high 15 cycles, then wb_err_o. STATUS=0x0101. Write STATUS -> 0.
5. Abort and reset: drop wb_cyc_i 2 cycles into FWD -> no ack/err, IDLE. Assert reset during FWD -> strobes 0 next edge, cpu_reset_o=1.
6. RAM_OUT: ram_out_i=0x5C -> read offset 2 returns 0x0000005C. Ack coincident with timeout -> ack, not err.
